// File: rtl/signed_seq_multiplier.sv
// ============================================================================
// Module   : signed_seq_multiplier
// Purpose  : Sequential radix-2 Booth multiplier, one iteration per clock,
//            operands loaded serially over a shared data_in bus.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module signed_seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 busy,
  output logic                 valid,
  output logic [2*WIDTH-1:0]   product
);

  localparam int                 c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_B = 2'd1,
    S_CALC   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;

  // Accumulator is one bit wider than the operands so A-M cannot overflow.
  logic [WIDTH:0]       r_m;
  logic [WIDTH:0]       r_a;
  logic [WIDTH-1:0]     r_q;
  logic                 r_q1;
  logic [c_CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_a_nx;
  logic [WIDTH-1:0]     w_q_nx;
  logic                 w_q1_nx;
  logic                 w_last;

  assign w_last = (r_count == c_LAST);

  always_comb begin
    unique case ({r_q[0], r_q1})
      2'b10:   w_sum = r_a - r_m;
      2'b01:   w_sum = r_a + r_m;
      default: w_sum = r_a;
    endcase
  end

  // Arithmetic right shift of the concatenation {A, Q, q_1}.
  assign w_a_nx  = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign w_q_nx  = {w_sum[0], r_q[WIDTH-1:1]};
  assign w_q1_nx = r_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    busy       = 1'b0;
    valid      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        busy       = 1'b1;
        w_state_nx = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        valid      = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m <= {data_in[WIDTH-1], data_in};
          end
        end
        S_LOAD_B: begin
          r_q     <= data_in;
          r_a     <= '0;
          r_q1    <= 1'b0;
          r_count <= '0;
        end
        S_CALC: begin
          r_a     <= w_a_nx;
          r_q     <= w_q_nx;
          r_q1    <= w_q1_nx;
          r_count <= r_count + c_ONE;
          // Capture on the final iteration so product is ready during DONE.
          if (w_last) begin
            r_product <= {w_a_nx[WIDTH-1:0], w_q_nx};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign product = r_product;

endmodule

`default_nettype wire
